// File: rtl/ahb_bm_input_stage_pkg.sv
// Shared bus-matrix definitions: AHB transfer/burst encodings, response
// constants and the input-stage pending-state type.
package ahb_bm_input_stage_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'b000,
        HBURST_INCR   = 3'b001,
        HBURST_WRAP4  = 3'b010,
        HBURST_INCR4  = 3'b011,
        HBURST_WRAP8  = 3'b100,
        HBURST_INCR8  = 3'b101,
        HBURST_WRAP16 = 3'b110,
        HBURST_INCR16 = 3'b111
    } hburst_e;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic {
        PEND_IDLE = 1'b0,
        PEND_PEND = 1'b1
    } pend_state_e;

endpackage

// File: rtl/ahb_bm_input_stage.sv
// Per-master input stage of the AHB bus matrix. Captures each address phase
// and holds it while no output stage accepts it, stalling the master until
// the held transfer has been accepted and its data phase completes.
module ahb_bm_input_stage
    import ahb_bm_input_stage_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSELS,
    input  logic [ADDR_WIDTH-1:0] HADDRS,
    input  logic [1:0]            HTRANSS,
    input  logic                  HWRITES,
    input  logic [2:0]            HSIZES,
    input  logic [2:0]            HBURSTS,
    input  logic [3:0]            HPROTS,
    input  logic                  HMASTLOCKS,
    input  logic                  HREADYS,
    input  logic                  addr_in_phase,
    input  logic                  data_in_phase,
    input  logic                  HREADYM,
    input  logic                  HRESPM,
    output logic [ADDR_WIDTH-1:0] HADDRM,
    output logic [1:0]            HTRANSM,
    output logic                  HWRITEM,
    output logic [2:0]            HSIZEM,
    output logic [2:0]            HBURSTM,
    output logic [3:0]            HPROTM,
    output logic                  HMASTLOCKM,
    output logic                  active_trans,
    output logic                  HREADYOUTS,
    output logic                  HRESPS
);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [1:0]            trans;
        logic                  write;
        logic [2:0]            size;
        logic [2:0]            burst;
        logic [3:0]            prot;
        logic                  lock;
    } hold_t;

    pend_state_e pend_state;
    hold_t       hold;
    logic        trans_valid;
    logic        pend;

    // Only NONSEQ/SEQ in a ready cycle are real address phases.
    assign trans_valid = HSELS & HTRANSS[1] & HREADYS;
    assign pend        = (pend_state == PEND_PEND);

    // Holding register and pending FSM. While pending, HREADYOUTS is low so
    // HREADYS cannot rise and the captured transfer stays stable.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            pend_state <= PEND_IDLE;
            hold       <= '0;
        end else begin
            if (trans_valid) begin
                hold.addr  <= HADDRS;
                hold.trans <= HTRANSS;
                hold.write <= HWRITES;
                hold.size  <= HSIZES;
                hold.burst <= HBURSTS;
                hold.prot  <= HPROTS;
                hold.lock  <= HMASTLOCKS;
            end
            case (pend_state)
                PEND_IDLE: if (trans_valid && !addr_in_phase) pend_state <= PEND_PEND;
                PEND_PEND: if (addr_in_phase)                 pend_state <= PEND_IDLE;
                default:                                      pend_state <= PEND_IDLE;
            endcase
        end
    end

    // Address/control mux: held copy while pending, live master bus otherwise,
    // with the transfer type squashed to IDLE when this port is not selected.
    always_comb begin
        if (pend) begin
            HADDRM     = hold.addr;
            HTRANSM    = hold.trans;
            HWRITEM    = hold.write;
            HSIZEM     = hold.size;
            HBURSTM    = hold.burst;
            HPROTM     = hold.prot;
            HMASTLOCKM = hold.lock;
        end else begin
            HADDRM     = HADDRS;
            HTRANSM    = HSELS ? HTRANSS : HTRANS_IDLE;
            HWRITEM    = HWRITES;
            HSIZEM     = HSIZES;
            HBURSTM    = HBURSTS;
            HPROTM     = HPROTS;
            HMASTLOCKM = HMASTLOCKS;
        end
    end

    // Request, ready and response towards arbiters and master.
    always_comb begin
        active_trans = pend | (HSELS & HTRANSS[1]);
        HREADYOUTS   = data_in_phase ? HREADYM : ~pend;
        HRESPS       = data_in_phase ? HRESPM  : HRESP_OKAY;
    end

endmodule

// File: tb/tb_ahb_bm_input_stage.sv
// Bench for the AHB bus-matrix input stage: directed test-plan steps followed
// by random traffic checked against a transfer-level reference model.
module tb_ahb_bm_input_stage;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        sel;
    logic [31:0] addr;
    logic [1:0]  trans;
    logic        write;
    logic [2:0]  size;
    logic [2:0]  burst;
    logic [3:0]  prot;
    logic        lock;
    logic        readys;
    logic        aip;
    logic        dip;
    logic        readym;
    logic        respm;

    logic [31:0] haddrm;
    logic [1:0]  htransm;
    logic        hwritem;
    logic [2:0]  hsizem;
    logic [2:0]  hburstm;
    logic [3:0]  hprotm;
    logic        hmastlockm;
    logic        active;
    logic        readyout;
    logic        resps;

    int checks = 0;
    int errors = 0;

    // Reference model: is a transfer waiting, and which transfer was last seen.
    bit          m_pend;
    logic [31:0] m_addr;
    logic [1:0]  m_trans;
    logic        m_write;
    logic [2:0]  m_size;
    logic [2:0]  m_burst;
    logic [3:0]  m_prot;
    logic        m_lock;

    always #5 HCLK = ~HCLK;

    ahb_bm_input_stage #(.ADDR_WIDTH(32)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .HSELS(sel), .HADDRS(addr), .HTRANSS(trans), .HWRITES(write),
        .HSIZES(size), .HBURSTS(burst), .HPROTS(prot), .HMASTLOCKS(lock),
        .HREADYS(readys), .addr_in_phase(aip), .data_in_phase(dip),
        .HREADYM(readym), .HRESPM(respm),
        .HADDRM(haddrm), .HTRANSM(htransm), .HWRITEM(hwritem),
        .HSIZEM(hsizem), .HBURSTM(hburstm), .HPROTM(hprotm),
        .HMASTLOCKM(hmastlockm), .active_trans(active),
        .HREADYOUTS(readyout), .HRESPS(resps)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pend = 0;
        {m_addr, m_trans, m_write, m_size, m_burst, m_prot, m_lock} = '0;
    endtask

    // Compare every output against what the model says the port should show now.
    task automatic check_model(input string tag);
        bit req;
        req = sel && (trans == 2'b10 || trans == 2'b11);
        chk({tag, ".addr"},   haddrm,            m_pend ? m_addr : addr);
        chk({tag, ".trans"},  32'(htransm),      32'(m_pend ? m_trans : (sel ? trans : 2'b00)));
        chk({tag, ".write"},  32'(hwritem),      32'(m_pend ? m_write : write));
        chk({tag, ".size"},   32'(hsizem),       32'(m_pend ? m_size : size));
        chk({tag, ".burst"},  32'(hburstm),      32'(m_pend ? m_burst : burst));
        chk({tag, ".prot"},   32'(hprotm),       32'(m_pend ? m_prot : prot));
        chk({tag, ".lock"},   32'(hmastlockm),   32'(m_pend ? m_lock : lock));
        chk({tag, ".active"}, 32'(active),       32'(m_pend || req));
        chk({tag, ".ready"},  32'(readyout),     32'(dip ? readym : !m_pend));
        chk({tag, ".resp"},   32'(resps),        32'(dip ? respm : 1'b0));
    endtask

    // One clock: check combinational outputs, advance the model at the edge,
    // and return at the falling edge ready for the next inputs.
    task automatic step(input string tag);
        bit captured;
        #1;
        check_model(tag);
        @(posedge HCLK);
        captured = sel && trans[1] && readys;
        if (m_pend) begin
            if (aip) m_pend = 0;
        end else if (captured && !aip) begin
            m_pend = 1;
        end
        if (captured) begin
            m_addr = addr; m_trans = trans; m_write = write; m_size = size;
            m_burst = burst; m_prot = prot; m_lock = lock;
        end
        @(negedge HCLK);
    endtask

    task automatic idle_bus();
        sel = 0; trans = 2'b00; addr = 32'h0; write = 0; size = 3'd2;
        burst = 3'd0; prot = 4'h3; lock = 0; readys = 1;
        aip = 0; dip = 0; readym = 1; respm = 0;
    endtask

    initial begin
        idle_bus();
        addr = 32'h0000_5A5A;
        HRESETn = 0;
        model_reset();
        #12;
        // Reset state
        chk("rst.trans",  32'(htransm),  32'h0);
        chk("rst.ready",  32'(readyout), 32'h1);
        chk("rst.resp",   32'(resps),    32'h0);
        chk("rst.active", 32'(active),   32'h0);
        chk("rst.addr",   haddrm,        32'h0000_5A5A);
        @(negedge HCLK);
        HRESETn = 1;
        @(negedge HCLK);

        // Zero-wait pass-through
        sel = 1; trans = 2'b10; addr = 32'h0000_1000; aip = 1;
        #1;
        chk("zw.addr",  haddrm,        32'h0000_1000);
        chk("zw.trans", 32'(htransm),  32'h2);
        step("zw.a");
        sel = 0; trans = 2'b00; aip = 0; dip = 1; readym = 0;
        #1;
        chk("zw.notpend", 32'(active),   32'h0);
        chk("zw.wait",    32'(readyout), 32'h0);
        step("zw.d0");
        readym = 1;
        #1;
        chk("zw.done", 32'(readyout), 32'h1);
        step("zw.d1");
        idle_bus();

        // Held transfer, master changes its bus while held
        sel = 1; trans = 2'b10; write = 1; addr = 32'h2000_0040; lock = 1;
        step("held.a");
        readys = 0; addr = 32'hDEAD_BEEF; write = 0; lock = 0; trans = 2'b00; sel = 0;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("held.addr",   haddrm,           32'h2000_0040);
            chk("held.write",  32'(hwritem),     32'h1);
            chk("held.lock",   32'(hmastlockm),  32'h1);
            chk("held.trans",  32'(htransm),     32'h2);
            chk("held.active", 32'(active),      32'h1);
            chk("held.ready",  32'(readyout),    32'h0);
            step("held.w");
        end
        aip = 1;
        #1;
        chk("held.acc.addr",  haddrm,        32'h2000_0040);
        chk("held.acc.ready", 32'(readyout), 32'h0);
        step("held.acc");
        aip = 0; dip = 1; readym = 1; readys = 1;
        #1;
        chk("held.idle.active", 32'(active),   32'h0);
        chk("held.dp.ready",    32'(readyout), 32'h1);
        chk("held.dp.addr",     haddrm,        32'hDEAD_BEEF);
        step("held.dp");

        // Error pass-through
        dip = 1; readym = 0; respm = 1;
        #1;
        chk("err1.resp",  32'(resps),    32'h1);
        chk("err1.ready", 32'(readyout), 32'h0);
        step("err1");
        readym = 1;
        #1;
        chk("err2.resp",  32'(resps),    32'h1);
        chk("err2.ready", 32'(readyout), 32'h1);
        step("err2");
        idle_bus();

        // Reset while pending
        sel = 1; trans = 2'b11; addr = 32'h3000_0000;
        step("rp.a");
        sel = 0; trans = 2'b00; readys = 0;
        #1;
        chk("rp.pend", 32'(readyout), 32'h0);
        #1;
        HRESETn = 0;
        model_reset();
        #1;
        chk("rp.trans",  32'(htransm),  32'h0);
        chk("rp.ready",  32'(readyout), 32'h1);
        chk("rp.active", 32'(active),   32'h0);
        @(negedge HCLK);
        HRESETn = 1;
        readys = 1;
        step("rp.after");

        // IDLE and BUSY while selected never pend
        sel = 1; trans = 2'b00;
        #1;
        chk("idle.active", 32'(active), 32'h0);
        step("idle");
        trans = 2'b01;
        #1;
        chk("busy.active", 32'(active), 32'h0);
        step("busy");
        sel = 0;
        #1;
        chk("busy.ready", 32'(readyout), 32'h1);
        chk("busy.resp",  32'(resps),    32'h0);
        step("busy.after");

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            sel    = 1'($urandom_range(0, 3) != 0);
            trans  = 2'($urandom);
            addr   = $urandom;
            write  = 1'($urandom);
            size   = 3'($urandom);
            burst  = 3'($urandom);
            prot   = 4'($urandom);
            lock   = 1'($urandom);
            readys = m_pend ? 1'b0 : 1'($urandom_range(0, 3) != 0);
            aip    = 1'($urandom);
            dip    = 1'($urandom);
            readym = 1'($urandom);
            respm  = 1'($urandom_range(0, 5) == 0);
            step("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
